// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, registered syncs, blanking decode,
// line/frame strobes and frame counter. Optional interlace support via VTG_INTERLACE_EN.
module video_timing_gen #(
  parameter int H_ADDR     = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ADDR     = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
`ifdef VTG_INTERLACE_EN
  input  logic               interlace,
  output logic               field,
`endif
  output logic               hsync,
  output logic               vsync,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               display_on,
  output logic               hblank,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int     H_TOTAL   = H_ADDR + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL   = V_ADDR + V_FRONT + V_SYNC + V_BACK;
  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  if (H_ADDR == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ADDR == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_zero_len
    $fatal(1, "video_timing_gen: every timing length must be non-zero");
  end
  if (longint'(H_TOTAL) > CNT_RANGE || longint'(V_TOTAL) > CNT_RANGE) begin : g_too_wide
    $fatal(1, "video_timing_gen: H_TOTAL/V_TOTAL exceed 2^CNT_W");
  end
`ifdef VTG_INTERLACE_EN
  if (longint'(V_TOTAL) + 1 > CNT_RANGE) begin : g_il_too_wide
    $fatal(1, "video_timing_gen: interlaced V_TOTAL+1 exceeds 2^CNT_W");
  end
`endif

  // One extra bit so that totals equal to 2^CNT_W still compare correctly.
  localparam logic [CNT_W:0] H_ADDR_W   = (CNT_W+1)'(H_ADDR);
  localparam logic [CNT_W:0] H_LAST_W   = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] HS_START_W = (CNT_W+1)'(H_ADDR + H_FRONT);
  localparam logic [CNT_W:0] HS_END_W   = (CNT_W+1)'(H_ADDR + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_ADDR_W   = (CNT_W+1)'(V_ADDR);
  localparam logic [CNT_W:0] V_LAST_W   = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] VS_START_W = (CNT_W+1)'(V_ADDR + V_FRONT);
  localparam logic [CNT_W:0] VS_END_W   = (CNT_W+1)'(V_ADDR + V_FRONT + V_SYNC);
  localparam logic           HS_ACT     = (H_SYNC_POL != 0);
  localparam logic           VS_ACT     = (V_SYNC_POL != 0);

  logic [CNT_W-1:0]   hpos_q, hpos_d;
  logic [CNT_W-1:0]   vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [CNT_W:0]     v_last;
  logic               h_wrap, v_wrap;
`ifdef VTG_INTERLACE_EN
  logic               field_q, field_d;
`endif

  always_comb begin
`ifdef VTG_INTERLACE_EN
    // Odd field carries one extra blank line after the back porch.
    v_last  = field_q ? (CNT_W+1)'(V_TOTAL) : V_LAST_W;
    field_d = field_q;
`else
    v_last  = V_LAST_W;
`endif
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    h_wrap  = ({1'b0, hpos_q} == H_LAST_W);
    v_wrap  = ({1'b0, vpos_q} == v_last);
    if (reset) begin
      hpos_d  = '0;
      vpos_d  = '0;
      frame_d = '0;
`ifdef VTG_INTERLACE_EN
      field_d = 1'b0;
`endif
    end else if (ce) begin
      if (h_wrap) begin
        hpos_d = '0;
        if (v_wrap) begin
          vpos_d  = '0;
          frame_d = frame_q + FRAME_W'(1);
`ifdef VTG_INTERLACE_EN
          field_d = interlace & ~field_q;
`endif
        end else begin
          vpos_d = vpos_q + CNT_W'(1);
        end
      end else begin
        hpos_d = hpos_q + CNT_W'(1);
      end
    end
    // Decoding the next position keeps the registered syncs aligned with hpos/vpos.
    hsync_d = (({1'b0, hpos_d} >= HS_START_W) && ({1'b0, hpos_d} < HS_END_W)) ? HS_ACT : ~HS_ACT;
    vsync_d = (({1'b0, vpos_d} >= VS_START_W) && ({1'b0, vpos_d} < VS_END_W)) ? VS_ACT : ~VS_ACT;
  end

  always_ff @(posedge clk) begin
    hpos_q  <= hpos_d;
    vpos_q  <= vpos_d;
    frame_q <= frame_d;
    hsync_q <= hsync_d;
    vsync_q <= vsync_d;
`ifdef VTG_INTERLACE_EN
    field_q <= field_d;
`endif
  end

`ifdef VTG_INTERLACE_EN
  assign field = field_q;
`endif
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = frame_q;
  assign hblank      = ({1'b0, hpos_q} >= H_ADDR_W);
  assign vblank      = ({1'b0, vpos_q} >= V_ADDR_W);
  assign display_on  = ~hblank & ~vblank;
  assign line_start  = ce & ~reset & (hpos_q == '0);
  assign frame_start = line_start & (vpos_q == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 timing, a tiny active-high
// instance and an instance whose totals exactly fill the counter width.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut0: default parameters
  logic       r0 = 1'b1, c0 = 1'b1;
  logic       hs0, vs0, de0, hb0, vb0, ls0, fs0;
  logic [9:0] hp0, vp0;
  logic [7:0] fc0;
  // dut1: H 4/2/2/2, V 3/1/1/1, active-high syncs
  logic       r1 = 1'b1, c1 = 1'b1;
  logic       hs1, vs1, de1, hb1, vb1, ls1, fs1;
  logic [3:0] hp1, vp1;
  logic [7:0] fc1;
  // dut2: totals equal 2^CNT_W (8x8 with CNT_W = 3)
  logic       r2 = 1'b1, c2 = 1'b1;
  logic       hs2, vs2, de2, hb2, vb2, ls2, fs2;
  logic [2:0] hp2, vp2;
  logic [7:0] fc2;
`ifdef VTG_INTERLACE_EN
  logic il0 = 1'b0, il1 = 1'b0, il2 = 1'b0;
  logic fld0, fld1, fld2;
`endif

  video_timing_gen dut0 (
    .clk(clk), .reset(r0), .ce(c0),
`ifdef VTG_INTERLACE_EN
    .interlace(il0), .field(fld0),
`endif
    .hsync(hs0), .vsync(vs0), .hpos(hp0), .vpos(vp0), .display_on(de0),
    .hblank(hb0), .vblank(vb0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  video_timing_gen #(
    .H_ADDR(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ADDR(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CNT_W(4), .FRAME_W(8)
  ) dut1 (
    .clk(clk), .reset(r1), .ce(c1),
`ifdef VTG_INTERLACE_EN
    .interlace(il1), .field(fld1),
`endif
    .hsync(hs1), .vsync(vs1), .hpos(hp1), .vpos(vp1), .display_on(de1),
    .hblank(hb1), .vblank(vb1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  video_timing_gen #(
    .H_ADDR(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ADDR(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CNT_W(3), .FRAME_W(8)
  ) dut2 (
    .clk(clk), .reset(r2), .ce(c2),
`ifdef VTG_INTERLACE_EN
    .interlace(il2), .field(fld2),
`endif
    .hsync(hs2), .vsync(vs2), .hpos(hp2), .vpos(vp2), .display_on(de2),
    .hblank(hb2), .vblank(vb2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    r0 = 1'b1; c0 = 1'b1;
    step();
    checks++;
    if ({hp0, vp0, fc0} !== {10'd0, 10'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_pos got h=%0d v=%0d fc=%0d exp 0 0 0", hp0, vp0, fc0);
    end
    checks++;
    if ({hs0, vs0, de0, hb0, vb0, ls0, fs0} !== 7'b1110000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1110000", {hs0, vs0, de0, hb0, vb0, ls0, fs0});
    end
    r0 = 1'b0;
    #1;
    checks++;
    if ({ls0, fs0} !== 2'b11) begin
      failures++;
      $display("FAIL release_strobes got=%b exp=11", {ls0, fs0});
    end
  endtask

  task automatic test_hsync_line();
    logic exp_hs, exp_hb;
    for (int h = 0; h < 800; h++) begin
      exp_hs = !(h >= 656 && h < 752);
      exp_hb = (h >= 640);
      checks++;
      if ({hp0, vp0, hs0, vs0, hb0, vb0, de0, ls0, fs0} !==
          {10'(h), 10'd0, exp_hs, 1'b1, exp_hb, 1'b0, !exp_hb, h == 0, h == 0}) begin
        failures++;
        $display("FAIL line0 h=%0d got hp=%0d vp=%0d flags=%b exp flags=%b", h, hp0, vp0,
                 {hs0, vs0, hb0, vb0, de0, ls0, fs0},
                 {exp_hs, 1'b1, exp_hb, 1'b0, !exp_hb, h == 0, h == 0});
      end
      step();
    end
    checks++;
    if ({hp0, vp0, ls0, fs0} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL line1_start got h=%0d v=%0d ls=%b fs=%b exp 0 1 1 0", hp0, vp0, ls0, fs0);
    end
  endtask

  task automatic test_line_wrap();
    steps(7999);
    checks++;
    if ({hp0, vp0, ls0, hb0} !== {10'd799, 10'd10, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pre_wrap got h=%0d v=%0d ls=%b hb=%b exp 799 10 0 1", hp0, vp0, ls0, hb0);
    end
    step();
    checks++;
    if ({hp0, vp0, ls0, fs0, hb0} !== {10'd0, 10'd11, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL line_wrap got h=%0d v=%0d ls=%b fs=%b hb=%b exp 0 11 1 0 0", hp0, vp0, ls0, fs0, hb0);
    end
    step();
    checks++;
    if ({hp0, ls0} !== {10'd1, 1'b0}) begin
      failures++;
      $display("FAIL after_wrap got h=%0d ls=%b exp 1 0", hp0, ls0);
    end
  endtask

  task automatic test_ce_pattern();
    steps(99);
    checks++;
    if (hp0 !== 10'd100) begin
      failures++;
      $display("FAIL ce_start got h=%0d exp 100", hp0);
    end
    c0 = 1'b1; step();
    checks++;
    if (hp0 !== 10'd101) begin failures++; $display("FAIL ce_1 got h=%0d exp 101", hp0); end
    c0 = 1'b0; step();
    checks++;
    if ({hp0, vp0, ls0, fs0, hs0} !== {10'd101, 10'd11, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ce_0a got h=%0d v=%0d ls=%b fs=%b hs=%b exp 101 11 0 0 1", hp0, vp0, ls0, fs0, hs0);
    end
    step();
    checks++;
    if (hp0 !== 10'd101) begin failures++; $display("FAIL ce_0b got h=%0d exp 101", hp0); end
    c0 = 1'b1; step();
    checks++;
    if (hp0 !== 10'd102) begin failures++; $display("FAIL ce_1b got h=%0d exp 102", hp0); end
  endtask

  task automatic test_custom_frame();
    int h, v;
    r1 = 1'b1; c1 = 1'b1;
    step();
    r1 = 1'b0;
    #1;
    for (int i = 0; i < 60; i++) begin
      h = i % 10;
      v = i / 10;
      checks++;
      if ({hp1, vp1, hs1, vs1, hb1, vb1, de1, ls1, fs1, fc1} !==
          {4'(h), 4'(v), (h >= 6 && h < 8), v == 4, h >= 4, v >= 3, (h < 4 && v < 3),
           h == 0, i == 0, 8'd0}) begin
        failures++;
        $display("FAIL custom i=%0d got h=%0d v=%0d flags=%b fc=%0d", i, hp1, vp1,
                 {hs1, vs1, hb1, vb1, de1, ls1, fs1}, fc1);
      end
      step();
    end
    checks++;
    if ({hp1, vp1, fs1, fc1} !== {4'd0, 4'd0, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL custom_wrap got h=%0d v=%0d fs=%b fc=%0d exp 0 0 1 1", hp1, vp1, fs1, fc1);
    end
  endtask

  task automatic test_ce_strobe();
    c1 = 1'b0;
    #1;
    checks++;
    if ({ls1, fs1} !== 2'b00) begin
      failures++;
      $display("FAIL ce0_strobe got=%b exp=00", {ls1, fs1});
    end
    step();
    checks++;
    if ({hp1, vp1, fc1, ls1, fs1} !== {4'd0, 4'd0, 8'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ce0_hold got h=%0d v=%0d fc=%0d ls=%b fs=%b exp 0 0 1 0 0", hp1, vp1, fc1, ls1, fs1);
    end
    c1 = 1'b1;
    #1;
    checks++;
    if ({ls1, fs1} !== 2'b11) begin
      failures++;
      $display("FAIL ce1_strobe got=%b exp=11", {ls1, fs1});
    end
  endtask

  task automatic test_frame_count_wrap();
    steps(255 * 60 - 1);
    checks++;
    if ({hp1, vp1, fc1} !== {4'd9, 4'd5, 8'd255}) begin
      failures++;
      $display("FAIL fc_pre_wrap got h=%0d v=%0d fc=%0d exp 9 5 255", hp1, vp1, fc1);
    end
    step();
    checks++;
    if ({hp1, vp1, fc1, fs1} !== {4'd0, 4'd0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL fc_wrap got h=%0d v=%0d fc=%0d fs=%b exp 0 0 0 1", hp1, vp1, fc1, fs1);
    end
  endtask

  task automatic test_reset_ce0();
    steps(106);
    checks++;
    if ({hp1, vp1, hs1, vs1, fc1} !== {4'd6, 4'd4, 1'b1, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL pre_reset got h=%0d v=%0d hs=%b vs=%b fc=%0d exp 6 4 1 1 1", hp1, vp1, hs1, vs1, fc1);
    end
    c1 = 1'b0; r1 = 1'b1;
    step();
    checks++;
    if ({hp1, vp1, hs1, vs1, fc1, de1, ls1, fs1} !== {4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ce0 got h=%0d v=%0d hs=%b vs=%b fc=%0d de=%b ls=%b fs=%b exp 0 0 0 0 0 1 0 0",
               hp1, vp1, hs1, vs1, fc1, de1, ls1, fs1);
    end
    r1 = 1'b0; c1 = 1'b1;
  endtask

  task automatic test_full_width();
    int h, v;
    r2 = 1'b1; c2 = 1'b1;
    step();
    r2 = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      h = i % 8;
      v = i / 8;
      checks++;
      if ({hp2, vp2, hs2, vs2, hb2, vb2, de2, ls2, fs2, fc2} !==
          {3'(h), 3'(v), !(h >= 5 && h < 7), !(v >= 5 && v < 7), h >= 4, v >= 4,
           (h < 4 && v < 4), h == 0, i == 0, 8'd0}) begin
        failures++;
        $display("FAIL fullw i=%0d got h=%0d v=%0d flags=%b fc=%0d", i, hp2, vp2,
                 {hs2, vs2, hb2, vb2, de2, ls2, fs2}, fc2);
      end
      step();
    end
    checks++;
    if ({hp2, vp2, fs2, fc2} !== {3'd0, 3'd0, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL fullw_wrap got h=%0d v=%0d fs=%b fc=%0d exp 0 0 1 1", hp2, vp2, fs2, fc2);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_line_wrap();
    test_ce_pattern();
    test_custom_frame();
    test_ce_strobe();
    test_frame_count_wrap();
    test_reset_ce0();
    test_full_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator: the next generation of the fixed 640x480 sync generator.
- All horizontal and vertical timing lengths and sync polarities are set by parameters.
- Adds a pixel clock-enable, blanking flags, line/frame start strobes and a frame counter.
- Sits between the pixel clock domain and the pattern/pixel logic; drives VGA sync pins and position buses.

Parameters:
- H_ADDR, 640, visible pixels per line
- H_FRONT, 16, right border + front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BACK, 48, back porch + left border, pixels
- V_ADDR, 480, visible lines per frame
- V_FRONT, 10, bottom border + front porch, lines
- V_SYNC, 2, vsync pulse height, lines
- V_BACK, 33, back porch + top border, lines
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level (0 = active-low)
- CNT_W, 10, width of hpos/vpos
- FRAME_W, 8, width of frame_count

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous reset, active-high
- ce  in  1  pixel advance enable; tie 1 for one pixel per clk
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- hpos  out  CNT_W  horizontal position; 0 = first visible pixel
- vpos  out  CNT_W  vertical position; 0 = first visible line
- display_on  out  1  hpos < H_ADDR and vpos < V_ADDR
- hblank  out  1  hpos >= H_ADDR
- vblank  out  1  vpos >= V_ADDR
- line_start  out  1  one-pixel strobe at hpos == 0
- frame_start  out  1  one-pixel strobe at hpos == 0 and vpos == 0
- frame_count  out  FRAME_W  completed-frame counter

Behaviour:
- Constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
- Elaboration: fail with a fatal error if H_TOTAL or V_TOTAL > 2^CNT_W, or if any length is 0.
- Reset (synchronous, highest priority, overrides ce):
  - Next cycle: hpos = 0, vpos = 0, frame_count = 0.
  - hsync and vsync at their inactive level.
  - line_start and frame_start = 0 while reset is high.
- Counters are registered and advance only on clk edges with ce = 1:
  - hpos: 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0.
  - vpos increments on the hpos wrap; at V_TOTAL-1 it wraps to 0.
  - frame_count increments on the (H_TOTAL-1, V_TOTAL-1) -> (0, 0) transition; modulo 2^FRAME_W.
- ce = 0: every register holds. Strobes are 0. Level outputs stay consistent with the held position.
- hsync is registered, zero lag relative to hpos (decode from next-state values):
  - Active exactly when H_ADDR+H_FRONT <= hpos < H_ADDR+H_FRONT+H_SYNC.
- vsync, same rule on vpos:
  - Active exactly when V_ADDR+V_FRONT <= vpos < V_ADDR+V_FRONT+V_SYNC, i.e. exactly V_SYNC lines.
- display_on, hblank, vblank: combinational decode of the registered hpos/vpos.
  - After reset: display_on = 1, hblank = 0, vblank = 0.
- Strobes are combinational and high for exactly one advancing pixel:
  - line_start = ce & ~reset & (hpos == 0).
  - frame_start = line_start & (vpos == 0).
- All arithmetic is unsigned CNT_W bits; comparisons use widened constants, so there is no overflow at the maximum totals.

Optional Feature:
- Macro: VTG_INTERLACE_EN.
- Defined: adds input `interlace` (1 bit) and output `field` (1 bit, reset 0).
  - With interlace = 1: field toggles at each frame wrap.
  - When field = 1, the vertical total is V_TOTAL+1: an extra blank line is inserted at the end of V_BACK, so vpos reaches V_TOTAL before wrapping.
  - vsync timing is unchanged.
  - frame_count increments per field.
  - With interlace = 0: field holds 0 and timing is progressive.
  - A change of interlace takes effect at the next frame wrap.
- Undefined: no interlace/field ports; strictly progressive timing.

Test Plan:
- Defaults, ce = 1, reset then run 1 frame:
  - hsync low exactly for hpos 656..751.
  - vsync low exactly for vpos 490..491 (2 lines).
  - 800x525 = 420000 cycles per frame.
- Line wrap: at hpos = 799, vpos = 10, next cycle -> hpos = 0, vpos = 11; line_start = 1 for that one cycle.
- Frame wrap: from (799, 524), next -> (0, 0); frame_start = 1; frame_count 0 -> 1. Force 255 frames -> frame_count wraps to 0.
- ce pattern 1,0,0,1 at hpos = 100: hpos reads 101, 101, 101, 102; strobes never high while ce = 0.
- Reset asserted at (300, 200) with ce = 0: next cycle (0, 0); hsync/vsync inactive; frame_count = 0; display_on = 1.
- Custom params H = 4/2/2/2, V = 3/1/1/1, H_SYNC_POL = V_SYNC_POL = 1:
  - hsync high only at hpos 6..7.
  - vsync high only at vpos 4.
  - Frame length 10x6 = 60 cycles.
